dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter XLEN, default 32, data path width; only 32 is supported.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 clk  in  1  single clock; every register samples on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 MemReadM  in  1  MEM-stage load request.
REQ-006 MemWriteM  in  1  MEM-stage store request.
REQ-007 funct3M  in  3  access size and type, RV32I encoding.
REQ-008 ALUResultM  in  ADDR_W  effective byte address.
REQ-009 WriteDataM  in  XLEN  store data, LSB-aligned.
REQ-010 stallM  out  1  freeze the pipeline at and before MEM.
REQ-011 RD_data  out  XLEN  registered raw memory word for the load extender.
REQ-012 byteAddrM  out  2  registered byte offset ALUResultM[1:0] of the captured access.
REQ-013 rd_validM  out  1  one-cycle pulse: RD_data and byteAddrM are valid.
REQ-014 misalignM  out  1  one-cycle pulse: misaligned access trapped.
REQ-015 dreq_valid / dreq_ready  out / in  1 / 1  request handshake.
REQ-016 dreq_we  out  1  write request.
REQ-017 dreq_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0.
REQ-018 dreq_wdata / dreq_be  out / out  XLEN / 4  lane-aligned store data and byte enables.
REQ-019 drsp_valid / drsp_rdata  in / in  1 / XLEN  read response; no backpressure.

Function
REQ-020 FSM states: IDLE, REQ, WAIT, DONE.
REQ-021 IDLE with MemReadM or MemWriteM: latch address, funct3M, and lane-aligned data/be; stallM=1 combinationally; go to REQ next cycle.
REQ-022 REQ: dreq_valid=1 and request fields held stable until dreq_ready; stallM=1.
REQ-023 REQ handshake on a read goes to WAIT; on a write goes to DONE (posted).
REQ-024 WAIT: stallM=1; on drsp_valid, RD_data <= drsp_rdata, then go to DONE.
REQ-025 DONE: stallM=0, rd_validM=1 for reads only; return to IDLE next cycle.
REQ-026 A drsp_valid arriving in IDLE, REQ or DONE shall be ignored.
REQ-027 Zero-wait read: stallM high for exactly 3 cycles; rd_validM asserted in the 4th.
REQ-028 MemReadM and MemWriteM both high: the access is treated as a write.
REQ-029 Store lanes, with off = ALUResultM[1:0]:
- funct3M 000: be = 4'b0001 << off; byte replicated to all 4 lanes.
- funct3M 001: be = 4'b0011 << {off[1],0}; halfword replicated to both halves.
- funct3M 010: be = 4'hF.
REQ-030 Misaligned access: halfword with off[0]=1, or word with off!=0.
REQ-031 Reads shall drive dreq_be = 4'hF.
REQ-032 RD_data and byteAddrM shall hold their values until the next read completes.

Reset
REQ-033 Reset shall force state IDLE.
REQ-034 Reset shall force stallM, rd_validM, misalignM, dreq_valid, dreq_we, dreq_addr, dreq_wdata, dreq_be, RD_data and byteAddrM to 0.
REQ-035 Reset mid-transaction shall abandon the access: dreq_valid low the next cycle; any late response is ignored.

Configuration
REQ-036 Macro DMEM_CTRL_MISALIGN_TRAP_EN, defined:
- a misaligned access issues no bus request;
- IDLE goes directly to DONE, giving 1 stall cycle;
- misalignM pulses in DONE; rd_validM stays 0.
REQ-037 Macro DMEM_CTRL_MISALIGN_TRAP_EN, undefined:
- misalignM is tied to 0;
- misaligned accesses proceed on the word-aligned address with the lane rules of REQ-029.

Verification
REQ-038 lw at 0x100, ready immediate, rsp 1 cycle later with 0xDEADBEEF -> stall for 3 cycles, then rd_validM=1, RD_data=0xDEADBEEF, byteAddrM=0.
REQ-039 sb 0xA5 at 0x203 -> dreq_addr=0x200, be=4'b1000, wdata=0xA5A5A5A5, we=1, no rd_validM.
REQ-040 lh at 0x102, dreq_ready held low 4 cycles -> request stable throughout, stall lasts 7 cycles, byteAddrM=2.
REQ-041 lw at 0x101 with macro defined -> no dreq_valid, misalignM pulse after 1 stall cycle; macro undefined -> request to 0x100.
REQ-042 reset asserted in WAIT, stray drsp_valid afterwards -> state IDLE, RD_data=0, rd_validM=0.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage data memory controller.
// Turns a pipeline load/store into a single valid/ready bus request, stalls the
// pipeline until the access finishes, and registers the raw load word and its
// byte offset for the downstream load extender.
// Optional feature: define DMEM_CTRL_MISALIGN_TRAP_EN to trap misaligned
// accesses (no bus request, misalignM pulse) instead of issuing them on the
// word-aligned address.
module dmem_ctrl #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        funct3M,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [XLEN-1:0]   WriteDataM,
  output logic              stallM,
  output logic [XLEN-1:0]   RD_data,
  output logic [1:0]        byteAddrM,
  output logic              rd_validM,
  output logic              misalignM,
  output logic              dreq_valid,
  input  logic              dreq_ready,
  output logic              dreq_we,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [XLEN-1:0]   dreq_wdata,
  output logic [3:0]        dreq_be,
  input  logic              drsp_valid,
  input  logic [XLEN-1:0]   drsp_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Captured access (held stable on the bus while the request is pending)
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        off_reg;
  logic [3:0]        be_reg;
  logic [XLEN-1:0]   wdata_reg;
  logic              mis_reg;

  // Load result registers
  logic [XLEN-1:0]   rd_data_reg;
  logic [1:0]        byte_addr_reg;

  // Control decoded from the incoming access
  logic              access_req;
  logic              capture;
  logic              trap_in;
  logic [1:0]        off_in;
  logic [1:0]        size_in;
  logic [3:0]        be_store;
  logic [3:0]        be_in;
  logic [XLEN-1:0]   lane_wdata;

  // funct3M[2] only selects sign/zero extension, which happens downstream
  logic              unused_funct3_sign;
  assign unused_funct3_sign = funct3M[2];

  assign access_req = MemReadM | MemWriteM;
  assign off_in     = ALUResultM[1:0];
  assign size_in    = funct3M[1:0];

`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
  // Halfword on an odd byte or word on any non-zero offset cannot be served
  assign trap_in = ((size_in == 2'b01) && off_in[0]) ||
                   ((size_in == 2'b10) && (off_in != 2'b00));
`else
  // Misaligned accesses simply go out on the word-aligned address
  assign trap_in = 1'b0;
`endif

  // Store byte enables from access size and byte offset
  always_comb begin
    case (size_in)
      2'b00:   be_store = 4'b0001 << off_in;
      2'b01:   be_store = 4'b0011 << {off_in[1], 1'b0};
      default: be_store = 4'hF;
    endcase
  end

  // Loads always fetch the full word; the extender picks the lanes later
  assign be_in = MemWriteM ? be_store : 4'hF;

  // Replicate the LSB-aligned store data onto every byte lane so the lane
  // selected by the byte enables always carries the right bytes
  generate
    for (genvar gi = 0; gi < XLEN / 8; gi++) begin : g_lane
      assign lane_wdata[gi*8 +: 8] =
        (size_in == 2'b00) ? WriteDataM[7:0] :
        (size_in == 2'b01) ? WriteDataM[(gi % 2)*8 +: 8] :
                             WriteDataM[gi*8 +: 8];
    end
  endgenerate

  // Next-state and handshake/pipeline outputs
  always_comb begin
    state_next = state_reg;
    stallM     = 1'b0;
    dreq_valid = 1'b0;
    rd_validM  = 1'b0;
    misalignM  = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (access_req) begin
          stallM     = 1'b1;
          capture    = 1'b1;
          state_next = trap_in ? DONE : REQ;
        end
      end
      REQ: begin
        stallM     = 1'b1;
        dreq_valid = 1'b1;
        if (dreq_ready) begin
          // Writes are posted: no response is awaited
          state_next = we_reg ? DONE : WAIT;
        end
      end
      WAIT: begin
        stallM = 1'b1;
        if (drsp_valid) begin
          state_next = DONE;
        end
      end
      DONE: begin
        rd_validM  = ~we_reg & ~mis_reg;
`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
        misalignM  = mis_reg;
`endif
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Outputs read as zero while reset is held, whatever the inputs do
    if (reset) begin
      stallM     = 1'b0;
      dreq_valid = 1'b0;
      rd_validM  = 1'b0;
      misalignM  = 1'b0;
      capture    = 1'b0;
    end
  end

  // State register and capture of the access in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      off_reg   <= 2'b00;
      be_reg    <= 4'h0;
      wdata_reg <= '0;
      mis_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        // Both request bits high is treated as a store
        we_reg    <= MemWriteM;
        addr_reg  <= {ALUResultM[ADDR_W-1:2], 2'b00};
        off_reg   <= off_in;
        be_reg    <= be_in;
        wdata_reg <= lane_wdata;
        mis_reg   <= trap_in;
      end
    end
  end

  // Load data capture: only a response in WAIT is accepted, so strays are
  // dropped, and the values persist until the next load completes
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_reg   <= '0;
      byte_addr_reg <= 2'b00;
    end else if ((state_reg == WAIT) && drsp_valid) begin
      rd_data_reg   <= drsp_rdata;
      byte_addr_reg <= off_reg;
    end
  end

  assign dreq_we    = we_reg;
  assign dreq_addr  = addr_reg;
  assign dreq_be    = be_reg;
  assign dreq_wdata = wdata_reg;
  assign RD_data    = rd_data_reg;
  assign byteAddrM  = byte_addr_reg;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized scoreboard bench for dmem_ctrl.
// A driver plays the pipeline, a bus slave answers requests, and a monitor
// compares every bus request, load result and trap pulse against queues
// filled by a byte-level reference model.
module tb_dmem_ctrl;

  logic        clk;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        stallM;
  logic [31:0] RD_data;
  logic [1:0]  byteAddrM;
  logic        rd_validM, misalignM;
  logic        dreq_valid, dreq_ready, dreq_we;
  logic [31:0] dreq_addr, dreq_wdata;
  logic [3:0]  dreq_be;
  logic        drsp_valid;
  logic [31:0] drsp_rdata;

`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  dmem_ctrl #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .stallM(stallM), .RD_data(RD_data), .byteAddrM(byteAddrM),
    .rd_validM(rd_validM), .misalignM(misalignM),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_we(dreq_we),
    .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata), .dreq_be(dreq_be),
    .drsp_valid(drsp_valid), .drsp_rdata(drsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } req_t;
  typedef struct { logic [31:0] data; logic [1:0] off; } rd_t;
  req_t exp_req[$];
  rd_t  exp_rd[$];
  int   exp_mis[$];

  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  int cfg_ready_delay = 0;
  int cfg_rsp_delay   = 0;
  bit stray_en        = 0;

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus slave: ready after a configured delay, read data after a configured
  // delay, and random stray responses whenever no read is outstanding
  initial begin : slave
    bit          pend;
    int          rsp_cnt, rdy_cnt;
    logic [31:0] pend_data, w;
    pend = 0; rsp_cnt = 0; rdy_cnt = 0; pend_data = 0;
    dreq_ready = 0; drsp_valid = 0; drsp_rdata = 0;
    forever begin
      @(posedge clk);
      if (!reset && dreq_valid && dreq_ready) begin
        if (dreq_we) begin
          w = slave_mem.exists(dreq_addr) ? slave_mem[dreq_addr] : init_word(dreq_addr);
          for (int i = 0; i < 4; i++)
            if (dreq_be[i]) w[i*8 +: 8] = dreq_wdata[i*8 +: 8];
          slave_mem[dreq_addr] = w;
        end else begin
          pend      = 1;
          rsp_cnt   = cfg_rsp_delay;
          pend_data = slave_mem.exists(dreq_addr) ? slave_mem[dreq_addr] : init_word(dreq_addr);
        end
        rdy_cnt = 0;
      end
      @(negedge clk);
      drsp_valid = 0;
      if (pend) begin
        if (rsp_cnt == 0) begin
          drsp_valid = 1; drsp_rdata = pend_data; pend = 0;
        end else begin
          rsp_cnt--;
        end
      end else if (stray_en && $urandom_range(0, 3) == 0) begin
        drsp_valid = 1; drsp_rdata = $urandom;
      end
      if (dreq_valid) begin
        if (rdy_cnt >= cfg_ready_delay) dreq_ready = 1;
        else begin dreq_ready = 0; rdy_cnt++; end
      end else begin
        dreq_ready = 1'($urandom_range(0, 1));
        rdy_cnt    = 0;
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the expectation queues
  initial begin : monitor
    req_t r;
    rd_t  d;
    forever begin
      @(negedge clk); #2;
      if (dreq_valid) begin
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr %h expected no request", dreq_addr);
        end else begin
          r = exp_req[0];
          chk("req_addr", dreq_addr, r.addr);
          chk("req_we", {31'd0, dreq_we}, {31'd0, r.we});
          chk("req_be", {28'd0, dreq_be}, {28'd0, r.be});
          if (r.we) chk("req_wdata", dreq_wdata, r.wdata);
          if (dreq_ready) void'(exp_req.pop_front());
        end
      end
      if (rd_validM) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rd_valid: got RD_data %h expected no load result", RD_data);
        end else begin
          d = exp_rd.pop_front();
          chk("rd_data", RD_data, d.data);
          chk("byte_addr", {30'd0, byteAddrM}, {30'd0, d.off});
        end
      end
      if (misalignM) begin
        checks++;
        if (exp_mis.size() == 0) begin
          errors++;
          $display("FAIL unexpected_misalign: got misalignM 1 expected 0");
        end else void'(exp_mis.pop_front());
      end
    end
  end

  // One pipeline access: model the expected outcome, present it, wait for the
  // stall to drop and check its length
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int d, input int r);
    logic [1:0]  off;
    bit          mis, is_wr;
    req_t        q;
    rd_t         e;
    logic [31:0] word, w;
    int          exp_stall, stalls;
    off   = addr[1:0];
    is_wr = wr;
    mis   = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    word  = addr & 32'hFFFF_FFFC;
    if (TRAP && mis) begin
      exp_mis.push_back(1);
      exp_stall = 1;
    end else begin
      q.addr = word; q.we = is_wr;
      if (!is_wr) begin
        q.be = 4'hF; q.wdata = 32'h0;
      end else if (f3[1:0] == 2'b00) begin
        q.be = 4'(1 << off); q.wdata = {24'd0, wd[7:0]} * 32'h0101_0101;
      end else if (f3[1:0] == 2'b01) begin
        q.be = 4'(3 << (off & 2'b10)); q.wdata = {16'd0, wd[15:0]} * 32'h0001_0001;
      end else begin
        q.be = 4'hF; q.wdata = wd;
      end
      exp_req.push_back(q);
      w = model_mem.exists(word) ? model_mem[word] : init_word(word);
      if (is_wr) begin
        for (int i = 0; i < 4; i++)
          if (q.be[i]) w[i*8 +: 8] = q.wdata[i*8 +: 8];
        model_mem[word] = w;
        exp_stall = 1 + (d + 1);
      end else begin
        e.data = w; e.off = off;
        exp_rd.push_back(e);
        exp_stall = 1 + (d + 1) + (r + 1);
      end
    end
    cfg_ready_delay = d;
    cfg_rsp_delay   = r;
    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    stalls = 0;
    forever begin
      #2;
      if (!stallM) break;
      stalls++;
      if (stalls > 100) begin
        $display("FAIL stall_timeout: got >100 stall cycles expected %0d", exp_stall);
        break;
      end
      @(negedge clk);
    end
    MemReadM = 0; MemWriteM = 0;
    chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    $display("txn rd=%0d wr=%0d f3=%0d addr=%h wd=%h rdy_dly=%0d rsp_dly=%0d stalls=%0d",
             rd, wr, f3, addr, wd, d, r, stalls);
  endtask

  initial begin : main
    logic [2:0] rd_f3 [5];
    bit rd, wr;
    logic [2:0] f3;
    rd_f3[0] = 3'b000; rd_f3[1] = 3'b001; rd_f3[2] = 3'b010;
    rd_f3[3] = 3'b100; rd_f3[4] = 3'b101;

    // Reset with requests driven: every output must still read zero
    reset = 1; MemReadM = 1; MemWriteM = 1; funct3M = 3'b010;
    ALUResultM = 32'h123; WriteDataM = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_stall", {31'd0, stallM}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_validM}, 32'd0);
    chk("rst_misalign", {31'd0, misalignM}, 32'd0);
    chk("rst_dreq_valid", {31'd0, dreq_valid}, 32'd0);
    chk("rst_dreq_we", {31'd0, dreq_we}, 32'd0);
    chk("rst_dreq_addr", dreq_addr, 32'd0);
    chk("rst_dreq_wdata", dreq_wdata, 32'd0);
    chk("rst_dreq_be", {28'd0, dreq_be}, 32'd0);
    chk("rst_rd_data", RD_data, 32'd0);
    chk("rst_byte_addr", {30'd0, byteAddrM}, 32'd0);
    MemReadM = 0; MemWriteM = 0;
    @(negedge clk);
    reset = 0;

    // Directed scenarios
    slave_mem[32'h100] = 32'hDEAD_BEEF;
    model_mem[32'h100] = 32'hDEAD_BEEF;
    do_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 0);          // lw, zero wait
    do_access(0, 1, 3'b000, 32'h203, 32'h0000_00A5, 0, 0);  // sb at lane 3
    do_access(1, 0, 3'b001, 32'h102, 32'h0, 4, 0);          // lh, ready late
    do_access(1, 0, 3'b010, 32'h101, 32'h0, 0, 0);          // misaligned lw
    do_access(0, 1, 3'b001, 32'h201, 32'h0000_BEEF, 1, 0);  // misaligned sh
    do_access(1, 1, 3'b010, 32'h204, 32'hCAFE_F00D, 0, 0);  // both: write
    do_access(1, 0, 3'b010, 32'h204, 32'h0, 0, 2);          // read it back

    // Randomized traffic over a small window so loads see earlier stores
    stray_en = 1;
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 2))
        0:       begin rd = 1; wr = 0; end
        1:       begin rd = 0; wr = 1; end
        default: begin rd = 1; wr = 1; end
      endcase
      f3 = wr ? 3'($urandom_range(0, 2)) : rd_f3[$urandom_range(0, 4)];
      do_access(rd, wr, f3, 32'h400 + 32'($urandom_range(0, 31)), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end
    stray_en = 0;

    // Reset while waiting for a read response; the late response must be dropped
    begin
      req_t q;
      q.addr = 32'h300; q.we = 0; q.be = 4'hF; q.wdata = 32'h0;
      exp_req.push_back(q);
      cfg_ready_delay = 0; cfg_rsp_delay = 6;
      @(negedge clk);
      MemReadM = 1; funct3M = 3'b010; ALUResultM = 32'h300;
      @(negedge clk);
      @(negedge clk); #2;
      chk("stall_in_wait", {31'd0, stallM}, 32'd1);
      reset = 1; MemReadM = 0;
      @(negedge clk);
      reset = 0;
      #2;
      chk("abandon_dreq_valid", {31'd0, dreq_valid}, 32'd0);
      chk("abandon_stall", {31'd0, stallM}, 32'd0);
      repeat (10) begin
        @(negedge clk); #2;
        chk("idle_after_rst", {31'd0, dreq_valid | stallM}, 32'd0);
      end
      chk("rst_wait_rd_data", RD_data, 32'd0);
      chk("rst_wait_byte_addr", {30'd0, byteAddrM}, 32'd0);
    end

    repeat (3) @(negedge clk);
    chk("req_queue_empty", 32'(exp_req.size()), 32'd0);
    chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    chk("mis_queue_empty", 32'(exp_mis.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected completion within 500000 time units");
    $fatal(1, "timeout");
  end

endmodule
